// File: rtl/sfp_link_ctrl.sv
// Bring-up and recovery sequencer for a multi-lane SFP+ transceiver and PHY datapath.
// Define SFP_LINK_CTRL_STATS_EN to implement link_drop_count; otherwise it is tied to 0.
module sfp_link_ctrl #(
    parameter int LANES        = 2,
    parameter int RST_CYCLES   = 16,
    parameter int INIT_TIMEOUT = 1250000,
    parameter int LOCK_TIMEOUT = 125000,
    parameter int DEBOUNCE     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gt_reset_tx_done,
    input  logic             gt_reset_rx_done,
    input  logic [LANES-1:0] rx_block_lock,
    output logic             gt_reset_all,
    output logic             gt_reset_rx_datapath,
    output logic [LANES-1:0] link_up,
    output logic             all_up,
    output logic [7:0]       retry_count,
    output logic [15:0]      link_drop_count
);
    localparam int MAX_A = (RST_CYCLES > INIT_TIMEOUT) ? RST_CYCLES : INIT_TIMEOUT;
    localparam int MAX_T = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int DW    = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0] T_RST   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_INIT  = TW'(INIT_TIMEOUT - 1);
    localparam logic [TW-1:0] T_LOCK  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);

    localparam logic [2:0] RESET_ALL = 3'd0;
    localparam logic [2:0] WAIT_TX   = 3'd1;
    localparam logic [2:0] WAIT_RX   = 3'd2;
    localparam logic [2:0] WAIT_LOCK = 3'd3;
    localparam logic [2:0] UP        = 3'd4;
    localparam logic [2:0] RX_RESET  = 3'd5;

    logic             tx_meta, tx_s, rx_meta, rx_s;
    logic [LANES-1:0] lock_meta, lock_s;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [DW-1:0]    deb_q [LANES];
    logic [DW-1:0]    deb_d [LANES];
    logic             any_lost, retry_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_meta   <= 1'b0;
            tx_s      <= 1'b0;
            rx_meta   <= 1'b0;
            rx_s      <= 1'b0;
            lock_meta <= '0;
            lock_s    <= '0;
        end else begin
            tx_meta   <= gt_reset_tx_done;
            tx_s      <= tx_meta;
            rx_meta   <= gt_reset_rx_done;
            rx_s      <= rx_meta;
            lock_meta <= rx_block_lock;
            lock_s    <= lock_meta;
        end
    end

    // A lane counts only in UP, clears as soon as it relocks, and sticks at DEBOUNCE.
    always_comb begin
        any_lost = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            deb_d[i] = deb_q[i];
            if (lock_s[i]) begin
                deb_d[i] = '0;
            end else if (state_q == UP && deb_q[i] != DEB_MAX) begin
                deb_d[i] = deb_q[i] + 1'b1;
            end
            if (deb_q[i] == DEB_MAX) begin
                any_lost = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        if (!tx_s && (state_q == WAIT_RX || state_q == WAIT_LOCK || state_q == UP)) begin
            state_d   = RESET_ALL;
            retry_inc = 1'b1;
        end else begin
            case (state_q)
                RESET_ALL: if (timer_q == T_RST) state_d = WAIT_TX;
                WAIT_TX: begin
                    if (tx_s) begin
                        state_d = WAIT_RX;
                    end else if (timer_q == T_INIT) begin
                        state_d   = RESET_ALL;
                        retry_inc = 1'b1;
                    end
                end
                WAIT_RX: begin
                    if (rx_s) begin
                        state_d = WAIT_LOCK;
                    end else if (timer_q == T_INIT) begin
                        state_d   = RESET_ALL;
                        retry_inc = 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (&lock_s) begin
                        state_d = UP;
                    end else if (timer_q == T_LOCK) begin
                        state_d   = RX_RESET;
                        retry_inc = 1'b1;
                    end
                end
                UP: begin
                    if (any_lost) begin
                        state_d   = RX_RESET;
                        retry_inc = 1'b1;
                    end
                end
                RX_RESET: if (timer_q == T_RST) state_d = WAIT_RX;
                default:  state_d = RESET_ALL;
            endcase
        end
        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    end

    // Outputs decode the next state so they are registered yet change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= RESET_ALL;
            timer_q              <= '0;
            gt_reset_all         <= 1'b1;
            gt_reset_rx_datapath <= 1'b0;
            link_up              <= '0;
            all_up               <= 1'b0;
            retry_count          <= '0;
            for (int i = 0; i < LANES; i++) deb_q[i] <= '0;
        end else begin
            state_q              <= state_d;
            timer_q              <= timer_d;
            gt_reset_all         <= (state_d == RESET_ALL);
            gt_reset_rx_datapath <= (state_d == RX_RESET);
            link_up              <= (state_d == UP) ? lock_s : '0;
            all_up               <= (state_d == UP);
            if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
            for (int i = 0; i < LANES; i++) deb_q[i] <= deb_d[i];
        end
    end

`ifdef SFP_LINK_CTRL_STATS_EN
    logic drop_inc;
    assign drop_inc = (state_q == UP) && tx_s && any_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_drop_count <= '0;
        end else if (drop_inc && link_drop_count != 16'hFFFF) begin
            link_drop_count <= link_drop_count + 16'd1;
        end
    end
`else
    assign link_drop_count = '0;
`endif

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Scoreboard bench for sfp_link_ctrl: expected output events are derived from the sequencing
// rules with cycle arithmetic and checked by an independent monitor on the falling clock edge.
module tb_sfp_link_ctrl;
    localparam int RST  = 4;
    localparam int INIT = 100;
    localparam int LOCK = 50;
    localparam int DEB  = 8;

    localparam int K_RA = 0;
    localparam int K_RX = 1;
    localparam int K_UP = 2;
    localparam int K_DN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_done, rx_done;
    logic [1:0]  rx_block_lock;
    logic        gt_reset_all, gt_reset_rx_datapath, all_up;
    logic [1:0]  link_up;
    logic [7:0]  retry_count;
    logic [15:0] link_drop_count;

    sfp_link_ctrl #(
        .LANES       (2),
        .RST_CYCLES  (RST),
        .INIT_TIMEOUT(INIT),
        .LOCK_TIMEOUT(LOCK),
        .DEBOUNCE    (DEB)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .gt_reset_tx_done    (tx_done),
        .gt_reset_rx_done    (rx_done),
        .rx_block_lock       (rx_block_lock),
        .gt_reset_all        (gt_reset_all),
        .gt_reset_rx_datapath(gt_reset_rx_datapath),
        .link_up             (link_up),
        .all_up              (all_up),
        .retry_count         (retry_count),
        .link_drop_count     (link_drop_count)
    );

    always #5 clk = ~clk;

    // Number of rising edges since the last reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int kind;
        int at;
        int retry;
        int drops;
    } ev_t;

    ev_t evq[$];
    int  tests, fails;
    int  m_retry, m_drops;

    function automatic string kname(input int k);
        case (k)
            K_RA:    return "reset_all_rise";
            K_RX:    return "rx_reset_rise";
            K_UP:    return "all_up_rise";
            default: return "all_up_fall";
        endcase
    endfunction

    function automatic int urand(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    // Earliest exit cycle from a wait state entered at e whose condition is visible from v.
    function automatic int resolve(input int e, input int v, input int t);
        int s;
        s = (v > e + 1) ? v : e + 1;
        return (s <= e + t) ? s : -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic bump(input bit drop);
        if (m_retry < 255) m_retry++;
        if (drop && m_drops < 65535) m_drops++;
    endtask

    task automatic push(input int k, input int at);
        ev_t e;
        e.kind  = k;
        e.at    = at;
        e.retry = m_retry;
`ifdef SFP_LINK_CTRL_STATS_EN
        e.drops = m_drops;
`else
        e.drops = 0;
`endif
        evq.push_back(e);
    endtask

    // WAIT_LOCK entered at e_in, all lanes visibly locked from v; rx_done assumed high.
    task automatic recover_lock(input int e_in, input int v, output int up);
        int e;
        e = e_in;
        while (v > e + LOCK) begin
            bump(1'b0);
            push(K_RX, e + LOCK);
            e = e + LOCK + RST + 1;
        end
        up = (v > e + 1) ? v : e + 1;
        push(K_UP, up);
    endtask

    task automatic match_ev(input int k);
        ev_t e;
        tests++;
        if (evq.size() == 0) begin
            fails++;
            $display("FAIL unexpected %s at cycle %0d: got event, required none", kname(k), cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.at != cyc || e.retry != int'(retry_count)
                || e.drops != int'(link_drop_count)) begin
                fails++;
                $display("FAIL event: got %s@%0d retry=%0d drops=%0d, required %s@%0d retry=%0d drops=%0d",
                         kname(k), cyc, retry_count, link_drop_count,
                         kname(e.kind), e.at, e.retry, e.drops);
            end
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (evq.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("queue_drain", evq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gt_reset_all"}, int'(gt_reset_all), 1);
        check({tag, "_rx_datapath"}, int'(gt_reset_rx_datapath), 0);
        check({tag, "_link_up"}, int'(link_up), 0);
        check({tag, "_all_up"}, int'(all_up), 0);
        check({tag, "_retry_count"}, int'(retry_count), 0);
        check({tag, "_link_drop_count"}, int'(link_drop_count), 0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #3;
        rst_n   = 1'b1;
        m_retry = 0;
        m_drops = 0;
    endtask

    // Monitor: per-cycle link_up check, event matching and reset pulse widths.
    logic       p_ra, p_rx, p_up;
    int         ra_rise, rx_rise;
    logic [1:0] h1, h2, h3;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ra = 1'b1; p_rx = 1'b0; p_up = 1'b0;
                ra_rise = 0; rx_rise = 0;
                h1 = '0; h2 = '0; h3 = '0;
            end else begin
                check("link_up", int'(link_up), int'({2{all_up}} & h3));
                h3 = h2; h2 = h1; h1 = rx_block_lock;
                if (gt_reset_all && !p_ra) begin
                    match_ev(K_RA);
                    ra_rise = cyc;
                end
                if (!gt_reset_all && p_ra) check("reset_all_width", cyc - ra_rise, RST);
                if (gt_reset_rx_datapath && !p_rx) begin
                    match_ev(K_RX);
                    rx_rise = cyc;
                end
                if (!gt_reset_rx_datapath && p_rx) check("rx_reset_width", cyc - rx_rise, RST);
                if (gt_reset_all && gt_reset_rx_datapath) check("pulse_overlap", 1, 0);
                if (all_up && !p_up) match_ev(K_UP);
                if (!all_up && p_up) match_ev(K_DN);
                p_ra = gt_reset_all;
                p_rx = gt_reset_rx_datapath;
                p_up = all_up;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    int cursor, a, len, lane, r, e, v, up, t, t_rx, t_lk, e_rx, e_lk, last;

    initial begin
        tests = 0; fails = 0; m_retry = 0; m_drops = 0;
        tx_done = 1'b0; rx_done = 1'b0; rx_block_lock = 2'b00;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        release_reset();

        // Clean bring-up with randomised arrival of tx_done, rx_done and both locks.
        t    = urand(1, 20);
        t_rx = t + urand(1, 25);
        t_lk = t_rx + urand(1, 25);
        a    = urand(0, 5);
        e_rx = resolve(RST, t + 3, INIT);
        e_lk = resolve(e_rx, t_rx + 3, INIT);
        recover_lock(e_lk, t_lk + a + 3, up);
        goto(t);        tx_done = 1'b1;
        goto(t_rx);     rx_done = 1'b1;
        goto(t_lk);     rx_block_lock[0] = 1'b1;
        goto(t_lk + a); rx_block_lock[1] = 1'b1;
        goto(up + 1);
        check("bringup_retry", int'(retry_count), 0);
        cursor = up;

        // Lane drops: fixed 5 and 12 cycles on lane 0, then random short/long drops.
        for (int i = 0; i < 8; i++) begin
            a    = cursor + urand(3, 10);
            lane = (i < 2) ? 0 : urand(0, 1);
            if (i == 0)          len = 5;
            else if (i == 1)     len = 12;
            else if (i % 2 == 0) len = urand(1, DEB - 1);
            else                 len = urand(DEB, DEB + 6);
            if (len >= DEB) begin
                r = a + 3 + DEB;
                bump(1'b1);
                push(K_RX, r);
                push(K_DN, r);
                recover_lock(r + RST + 1, a + len + 3, up);
                cursor = up;
            end else begin
                cursor = a + len + 3;
            end
            goto(a);       rx_block_lock[lane] = 1'b0;
            goto(a + len); rx_block_lock[lane] = 1'b1;
        end
        goto(cursor + 1);

        // tx_done loss while UP forces a full reset.
        for (int i = 0; i < 2; i++) begin
            a = cursor + urand(3, 10);
            t = a + urand(1, 15);
            bump(1'b0);
            push(K_RA, a + 3);
            push(K_DN, a + 3);
            e_rx = resolve(a + 3 + RST, t + 3, INIT);
            recover_lock(e_rx + 1, 0, up);
            goto(a); tx_done = 1'b0;
            goto(t); tx_done = 1'b1;
            cursor = up;
        end

        // Lane 1 stays down through lock timeouts; first pass locks on the timeout cycle itself.
        for (int j = 0; j < 2; j++) begin
            a = cursor + urand(3, 10);
            goto(a); rx_block_lock[1] = 1'b0;
            r = a + 3 + DEB;
            bump(1'b1);
            push(K_RX, r);
            push(K_DN, r);
            e = r + RST + 1;
            v = (j == 0) ? e + (LOCK + RST + 1) + LOCK : e + urand(LOCK + 1, 3 * (LOCK + RST + 1));
            recover_lock(e, v, up);
            goto(v - 3); rx_block_lock[1] = 1'b1;
            cursor = up;
        end
        drain();

        // Asynchronous reset while UP, then repeated TX timeouts before a late bring-up.
        goto(cursor + 5);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_up");
        tx_done = 1'b0; rx_done = 1'b0; rx_block_lock = 2'b00;
        release_reset();
        for (int k = 1; k <= 3; k++) begin
            bump(1'b0);
            push(K_RA, k * (RST + INIT));
        end
        t = 3 * (RST + INIT) - 2 + urand(0, 20);
        goto(t); tx_done = 1'b1;
        e_rx = resolve(3 * (RST + INIT) + RST, t + 3, INIT);
        t_rx = t + urand(1, 10);
        e_lk = resolve(e_rx, t_rx + 3, INIT);
        t_lk = t_rx + urand(1, 10);
        recover_lock(e_lk, t_lk + 3, up);
        goto(t_rx); rx_done = 1'b1;
        goto(t_lk); rx_block_lock = 2'b11;
        cursor = up;

        // Saturate retry_count with lock timeouts, then reset in the middle of RX_RESET.
        a = cursor + 5;
        goto(a); rx_block_lock[1] = 1'b0;
        r = a + 3 + DEB;
        bump(1'b1);
        push(K_RX, r);
        push(K_DN, r);
        e    = r + RST + 1;
        last = e;
        for (int i = 0; i < 255; i++) begin
            bump(1'b0);
            last = e + LOCK;
            push(K_RX, last);
            e = e + LOCK + RST + 1;
        end
        goto(last + 2);
        drain();
        check("retry_saturated", int'(retry_count), 255);
        check("rx_reset_active", int'(gt_reset_rx_datapath), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rx_reset");
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
